// File: rtl/multi_rate_tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// multi_rate_tick_gen_pkg
//   Shared constants and types for the multi-rate tick generator.
//   - DEFAULT_CNT_W        : default half-period counter width
//   - HALF_* constants     : named half-periods at a 25 MHz system clock
//   - DEFAULT_HALF_TABLE   : packed reset half-periods, ch0 in the LSBs
//   - ch_action_e          : per-channel action selected each clock
//   - ch_sel_width()       : width of a channel-select field (never 0)
// -----------------------------------------------------------------------------
package multi_rate_tick_gen_pkg;

  localparam int DEFAULT_CNT_W  = 24;
  localparam int DEFAULT_NUM_CH = 4;

  localparam logic [DEFAULT_CNT_W-1:0] HALF_1HZ     = 24'd12500000;
  localparam logic [DEFAULT_CNT_W-1:0] HALF_10KHZ   = 24'd1250;
  localparam logic [DEFAULT_CNT_W-1:0] HALF_REFRESH = 24'd10000;
  localparam logic [DEFAULT_CNT_W-1:0] HALF_4KHZ    = 24'd3125;

  // ch0 = 1 Hz stopwatch base, ch1 = 10 kHz, ch2 = 1.25 kHz refresh, ch3 = 4 kHz tone
  localparam logic [DEFAULT_NUM_CH*DEFAULT_CNT_W-1:0] DEFAULT_HALF_TABLE =
    {HALF_4KHZ, HALF_REFRESH, HALF_10KHZ, HALF_1HZ};

  typedef enum logic [1:0] {
    ACT_CLEAR,  // global phase re-align
    ACT_HOLD,   // channel disabled: freeze phase
    ACT_COUNT,  // mid half-period
    ACT_WRAP    // terminal count: toggle and reload half-period
  } ch_action_e;

  // A one-channel build still needs a 1-bit select field.
  function automatic int ch_sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_rate_tick_gen_if.sv
// -----------------------------------------------------------------------------
// multi_rate_tick_gen_if
//   Control/status bundle of the tick generator.
//   master : drives ch_en, sync_clear, div_wr_en/ch/val; observes clk_out, tick
//   slave  : the generator itself
// -----------------------------------------------------------------------------
interface multi_rate_tick_gen_if
  import multi_rate_tick_gen_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int CNT_W  = DEFAULT_CNT_W
);
  localparam int CH_W = ch_sel_width(NUM_CH);

  logic [NUM_CH-1:0] ch_en;
  logic              sync_clear;
  logic              div_wr_en;
  logic [CH_W-1:0]   div_wr_ch;
  logic [CNT_W-1:0]  div_wr_val;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  modport master (
    output ch_en, sync_clear, div_wr_en, div_wr_ch, div_wr_val,
    input  clk_out, tick
  );

  modport slave (
    input  ch_en, sync_clear, div_wr_en, div_wr_ch, div_wr_val,
    output clk_out, tick
  );
endinterface

// File: rtl/multi_rate_tick_gen_tick_channel.sv
// -----------------------------------------------------------------------------
// multi_rate_tick_gen_tick_channel
//   One rate channel: half-period counter, shadow/active half-period pair,
//   square-wave toggle and registered rise strobe.
//   twentyFive_mhz_clk, reset : clock, async active-high reset
//   en          : run enable (level); low freezes the phase
//   sync_clear  : return to phase 0 and load shadow into active
//   wr_en/wr_val: shadow half-period write (already decoded for this channel)
//   clk_out     : 50% square wave, period 2*H clocks
//   tick        : one-cycle strobe in the cycle clk_out becomes 1
// -----------------------------------------------------------------------------
module multi_rate_tick_gen_tick_channel
  import multi_rate_tick_gen_pkg::*;
#(
  parameter int               CNT_W        = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(1)
) (
  input  logic             twentyFive_mhz_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clear,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_val,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] active_reg, active_next;
  logic [CNT_W-1:0] shadow_reg, shadow_next;
  logic             clk_out_reg, clk_out_next;
  logic             tick_reg, tick_next;
  logic [CNT_W-1:0] last_cnt;
  ch_action_e       action;

  // A programmed half-period of 0 behaves as 1, so the terminal count is 0.
  assign last_cnt = (active_reg == '0) ? '0 : active_reg - CNT_W'(1);

  always_comb begin
    action = ACT_COUNT;
    if (sync_clear)             action = ACT_CLEAR;
    else if (!en)               action = ACT_HOLD;
    else if (cnt_reg == last_cnt) action = ACT_WRAP;
  end

  always_comb begin
    cnt_next     = cnt_reg;
    clk_out_next = clk_out_reg;
    tick_next    = 1'b0;
    active_next  = active_reg;
    // A write in the same cycle as a reload is seen by that reload.
    shadow_next  = wr_en ? wr_val : shadow_reg;
    case (action)
      ACT_CLEAR: begin
        cnt_next     = '0;
        clk_out_next = 1'b0;
        active_next  = shadow_next;
      end
      ACT_HOLD: begin
        // Phase is frozen, so picking up a new half-period cannot cut one short.
        active_next = shadow_next;
      end
      ACT_WRAP: begin
        cnt_next     = '0;
        clk_out_next = ~clk_out_reg;
        tick_next    = ~clk_out_reg;
        active_next  = shadow_next;
      end
      default: begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge twentyFive_mhz_clk or posedge reset) begin
    if (reset) begin
      cnt_reg     <= '0;
      active_reg  <= DEFAULT_HALF;
      shadow_reg  <= DEFAULT_HALF;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      active_reg  <= active_next;
      shadow_reg  <= shadow_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
    end
  end

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;

endmodule

// File: rtl/multi_rate_tick_gen.sv
// -----------------------------------------------------------------------------
// multi_rate_tick_gen
//   NUM_CH independent square-wave / tick generators on the 25 MHz clock.
//   twentyFive_mhz_clk : system clock
//   reset              : async active-high, restores DEFAULT_HALF everywhere
//   bus (slave)        : ch_en, sync_clear, div_wr_en/ch/val in;
//                        clk_out, tick out (all straight from flops)
//   Writes addressed to a channel index >= NUM_CH match no channel and are
//   dropped.
// -----------------------------------------------------------------------------
module multi_rate_tick_gen
  import multi_rate_tick_gen_pkg::*;
#(
  parameter int                      NUM_CH       = DEFAULT_NUM_CH,
  parameter int                      CNT_W        = DEFAULT_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_HALF = DEFAULT_HALF_TABLE
) (
  input  logic                 twentyFive_mhz_clk,
  input  logic                 reset,
  multi_rate_tick_gen_if.slave bus
);

  localparam int CH_W = ch_sel_width(NUM_CH);

  logic [NUM_CH-1:0] clk_out_vec;
  logic [NUM_CH-1:0] tick_vec;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_hit;

    assign wr_hit = bus.div_wr_en && (bus.div_wr_ch == CH_W'(gi));

    multi_rate_tick_gen_tick_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF[gi*CNT_W +: CNT_W])
    ) u_channel (
      .twentyFive_mhz_clk (twentyFive_mhz_clk),
      .reset              (reset),
      .en                 (bus.ch_en[gi]),
      .sync_clear         (bus.sync_clear),
      .wr_en              (wr_hit),
      .wr_val             (bus.div_wr_val),
      .clk_out            (clk_out_vec[gi]),
      .tick               (tick_vec[gi])
    );
  end

  assign bus.clk_out = clk_out_vec;
  assign bus.tick    = tick_vec;

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Two generators: A (2 channels, halves ch0=3 ch1=1) and B (3 channels,
// halves ch0=3 ch1=1 ch2=2) so that an out-of-range write index exists on B.
module tb_multi_rate_tick_gen;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multi_rate_tick_gen_if #(.NUM_CH(2), .CNT_W(8)) bus_a ();
  multi_rate_tick_gen_if #(.NUM_CH(3), .CNT_W(8)) bus_b ();

  multi_rate_tick_gen #(.NUM_CH(2), .CNT_W(8), .DEFAULT_HALF({8'd1, 8'd3})) dut_a (
    .twentyFive_mhz_clk (clk),
    .reset              (reset),
    .bus                (bus_a)
  );

  multi_rate_tick_gen #(.NUM_CH(3), .CNT_W(8), .DEFAULT_HALF({8'd2, 8'd1, 8'd3})) dut_b (
    .twentyFive_mhz_clk (clk),
    .reset              (reset),
    .bus                (bus_b)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Each channel is described by where it sits inside its current half-period
  // (pos), which level it is showing, and the half-period it will use next.
  int nch[2] = '{2, 3};
  int dflt[2][3] = '{'{3, 1, 0}, '{3, 1, 2}};
  int m_pos[2][3];
  int m_act[2][3];
  int m_sh[2][3];
  bit m_lvl[2][3];
  bit m_tick[2][3];

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 3; c++) begin
        m_pos[d][c] = 0; m_lvl[d][c] = 0; m_tick[d][c] = 0;
        m_act[d][c] = dflt[d][c]; m_sh[d][c] = dflt[d][c];
      end
  endtask

  task automatic model_step(input int d, input int en_mask, input bit sc,
                            input bit we, input int wch, input int wval);
    for (int c = 0; c < nch[d]; c++) begin
      int sh_new;
      int h;
      sh_new = (we && wch == c) ? wval : m_sh[d][c];
      h = (m_act[d][c] == 0) ? 1 : m_act[d][c];
      m_tick[d][c] = 0;
      if (sc) begin
        m_pos[d][c] = 0; m_lvl[d][c] = 0; m_act[d][c] = sh_new;
      end else if (((en_mask >> c) & 1) == 0) begin
        m_act[d][c] = sh_new;
      end else if (m_pos[d][c] + 1 == h) begin
        m_pos[d][c] = 0;
        m_lvl[d][c] = !m_lvl[d][c];
        m_tick[d][c] = m_lvl[d][c];
        m_act[d][c] = sh_new;
      end else begin
        m_pos[d][c] = (m_pos[d][c] + 1) % 256;
      end
      m_sh[d][c] = sh_new;
    end
  endtask

  function automatic logic [7:0] m_vec(input int d, input bit want_tick);
    logic [7:0] v;
    v = 8'h00;
    for (int c = 0; c < nch[d]; c++) v[c] = want_tick ? m_tick[d][c] : m_lvl[d][c];
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else begin
      model_step(0, int'(bus_a.ch_en), bus_a.sync_clear, bus_a.div_wr_en,
                 int'(bus_a.div_wr_ch), int'(bus_a.div_wr_val));
      model_step(1, int'(bus_b.ch_en), bus_b.sync_clear, bus_b.div_wr_en,
                 int'(bus_b.div_wr_ch), int'(bus_b.div_wr_val));
    end
  end

  always @(negedge clk) begin
    check("cyc_clk_a",  8'(bus_a.clk_out), m_vec(0, 1'b0));
    check("cyc_tick_a", 8'(bus_a.tick),    m_vec(0, 1'b1));
    check("cyc_clk_b",  8'(bus_b.clk_out), m_vec(1, 1'b0));
    check("cyc_tick_b", 8'(bus_b.tick),    m_vec(1, 1'b1));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    bus_a.sync_clear = 1'b0; bus_a.div_wr_en = 1'b0; bus_a.div_wr_ch = '0; bus_a.div_wr_val = '0;
    bus_b.sync_clear = 1'b0; bus_b.div_wr_en = 1'b0; bus_b.div_wr_ch = '0; bus_b.div_wr_val = '0;
  endtask

  initial begin
    logic [1:0] ea;
    logic [1:0] ta;

    reset = 1'b1;
    idle_ctrl();
    bus_a.ch_en = 2'b11;
    bus_b.ch_en = 3'b111;
    repeat (3) step();
    check("rst_clk_a",  8'(bus_a.clk_out), 8'h00);
    check("rst_tick_a", 8'(bus_a.tick),    8'h00);
    reset = 1'b0;

    // Release from reset, then a ch0 write of 5 landing mid half-period:
    // first rise stays at edge 3, later halves are 5 clocks long.
    for (int e = 1; e <= 13; e++) begin
      step();
      ea[0] = (e >= 3 && e <= 7) || e == 13;
      ea[1] = (e % 2) == 1;
      ta[0] = (e == 3) || (e == 13);
      ta[1] = (e % 2) == 1;
      check("run_clk_a",  8'(bus_a.clk_out), 8'(ea));
      check("run_tick_a", 8'(bus_a.tick),    8'(ta));
      if (e == 1) begin
        bus_a.div_wr_en = 1'b1; bus_a.div_wr_ch = 1'b0; bus_a.div_wr_val = 8'd5;
      end
      if (e == 2) bus_a.div_wr_en = 1'b0;
    end

    // Freeze ch0 at position 1 of a 5-clock high half.
    step();
    bus_a.ch_en = 2'b10;
    for (int k = 0; k < 10; k++) begin
      step();
      check("frz_clk_a0",  8'(bus_a.clk_out[0]), 8'h01);
      check("frz_tick_a0", 8'(bus_a.tick[0]),    8'h00);
    end
    bus_a.ch_en = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("resume_clk_a0", 8'(bus_a.clk_out[0]), (k < 4) ? 8'h01 : 8'h00);
    end

    // sync_clear with a simultaneous ch1 write of 4.
    bus_a.sync_clear = 1'b1;
    bus_a.div_wr_en = 1'b1; bus_a.div_wr_ch = 1'b1; bus_a.div_wr_val = 8'd4;
    step();
    idle_ctrl();
    check("clr_clk_a",  8'(bus_a.clk_out), 8'h00);
    check("clr_tick_a", 8'(bus_a.tick),    8'h00);
    repeat (4) step();
    check("align_clk_a4",  8'(bus_a.clk_out), 8'h02);
    check("align_tick_a4", 8'(bus_a.tick),    8'h02);
    step();
    check("align_clk_a5",  8'(bus_a.clk_out), 8'h03);
    check("align_tick_a5", 8'(bus_a.tick),    8'h01);

    // Half-period 0 on A ch0; out-of-range index 3 on B; both with sync_clear.
    bus_a.sync_clear = 1'b1;
    bus_a.div_wr_en = 1'b1; bus_a.div_wr_ch = 1'b0; bus_a.div_wr_val = 8'd0;
    bus_b.sync_clear = 1'b1;
    bus_b.div_wr_en = 1'b1; bus_b.div_wr_ch = 2'd3; bus_b.div_wr_val = 8'd7;
    step();
    idle_ctrl();
    check("h0_clr_a", 8'(bus_a.clk_out), 8'h00);
    step();
    check("h0_clk_a1", 8'(bus_a.clk_out), 8'h01);
    check("oor_clk_b1", 8'(bus_b.clk_out), 8'h02);
    step();
    check("h0_clk_a2", 8'(bus_a.clk_out), 8'h00);
    check("oor_clk_b2", 8'(bus_b.clk_out), 8'h04);
    step();
    check("h0_clk_a3", 8'(bus_a.clk_out), 8'h01);
    check("oor_clk_b3", 8'(bus_b.clk_out), 8'h07);

    // Async reset between edges while A ch0 is high and ticking.
    #2 reset = 1'b1;
    #1;
    check("arst_clk_a",  8'(bus_a.clk_out), 8'h00);
    check("arst_tick_a", 8'(bus_a.tick),    8'h00);
    check("arst_clk_b",  8'(bus_b.clk_out), 8'h00);
    step();
    reset = 1'b0;
    step();
    check("dflt_clk_a1", 8'(bus_a.clk_out), 8'h02);
    step();
    check("dflt_clk_a2", 8'(bus_a.clk_out), 8'h00);
    step();
    check("dflt_clk_a3", 8'(bus_a.clk_out), 8'h03);

    // Randomized traffic checked against the reference every cycle.
    for (int n = 0; n < 4000; n++) begin
      step();
      for (int c = 0; c < 2; c++) bus_a.ch_en[c] = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < 3; c++) bus_b.ch_en[c] = ($urandom_range(0, 7) != 0);
      bus_a.sync_clear = ($urandom_range(0, 63) == 0);
      bus_b.sync_clear = ($urandom_range(0, 63) == 0);
      bus_a.div_wr_en  = ($urandom_range(0, 7) == 0);
      bus_b.div_wr_en  = ($urandom_range(0, 7) == 0);
      bus_a.div_wr_ch  = 1'($urandom_range(0, 1));
      bus_b.div_wr_ch  = 2'($urandom_range(0, 3));
      bus_a.div_wr_val = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 6));
      bus_b.div_wr_val = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end

    idle_ctrl();
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
